// File: rtl/maf_pkg.sv
// Shared constants and types for the boxcar moving-average filter.
package maf_pkg;

  // Default sample width and log2 of the window length.
  localparam int MAF_DATA_W   = 10;
  localparam int MAF_LOG2_WIN = 3;

  // Fill-tracking state: FILL until N samples are in the window, then RUN.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } maf_state_t;

  // The running sum of N samples needs log2(N) extra bits above the sample width.
  function automatic int maf_sum_w(input int data_w, input int log2_win);
    return data_w + log2_win;
  endfunction

  localparam int MAF_SUM_W = maf_sum_w(MAF_DATA_W, MAF_LOG2_WIN);

endpackage

// File: rtl/maf_delay_line.sv
// N-entry circular sample buffer. The entry under the write pointer is the
// oldest sample; it is presented combinationally so the running sum can
// retire it on the same edge that overwrites it.
module maf_delay_line
  import maf_pkg::*;
#(
  parameter int DATA_W   = MAF_DATA_W,
  parameter int LOG2_WIN = MAF_LOG2_WIN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  localparam int N = 1 << LOG2_WIN;

  logic [LOG2_WIN-1:0] wr_ptr_reg;
  logic [DATA_W-1:0]   entry_q [N];

  // Write pointer advances per accepted sample; wraps naturally at N.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_reg <= '0;
    end else if (wr_en) begin
      wr_ptr_reg <= wr_ptr_reg + LOG2_WIN'(1);
    end
  end

  // One register per window slot so the whole window can be cleared in a cycle.
  for (genvar gi = 0; gi < N; gi++) begin : g_entry
    logic [DATA_W-1:0] entry_reg;

    // Slot gi captures the incoming sample when the pointer selects it.
    always_ff @(posedge clk) begin
      if (reset || clear) begin
        entry_reg <= '0;
      end else if (wr_en && (wr_ptr_reg == LOG2_WIN'(gi))) begin
        entry_reg <= wr_data;
      end
    end

    assign entry_q[gi] = entry_reg;
  end

  assign rd_data = entry_q[wr_ptr_reg];

endmodule

// File: rtl/moving_average_filter.sv
// Boxcar moving-average filter: mean of the last 2^LOG2_WIN accepted samples,
// kept as an incremental running sum over a circular delay line.
// Optional macro MAF_WARMUP_EN: suppress out_valid until the window is full.
module moving_average_filter
  import maf_pkg::*;
#(
  parameter int DATA_W   = MAF_DATA_W,
  parameter int LOG2_WIN = MAF_LOG2_WIN
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [DATA_W+LOG2_WIN-1:0] out_sum,
  output logic                       filled
);

  localparam int N     = 1 << LOG2_WIN;
  localparam int SUM_W = maf_sum_w(DATA_W, LOG2_WIN);

  maf_state_t          state_reg, state_next;
  logic [LOG2_WIN-1:0] fill_cnt_reg, fill_cnt_next;
  logic [SUM_W-1:0]    sum_reg, sum_next;
  logic [DATA_W-1:0]   out_data_reg, out_data_next;
  logic                out_valid_reg, out_valid_next;
  logic                filled_reg, filled_next;
  logic [DATA_W-1:0]   oldest;
  logic                accept;

  // Flush beats a coincident sample: the sample is dropped.
  assign accept = in_valid && !flush;

  maf_delay_line #(
    .DATA_W   (DATA_W),
    .LOG2_WIN (LOG2_WIN)
  ) u_delay_line (
    .clk     (clk),
    .reset   (reset),
    .clear   (flush),
    .wr_en   (accept),
    .wr_data (in_data),
    .rd_data (oldest)
  );

  // State register with fill counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_FILL;
      fill_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      fill_cnt_reg <= fill_cnt_next;
    end
  end

  // Next state: count accepted samples in FILL, move to RUN on the Nth.
  always_comb begin
    state_next    = state_reg;
    fill_cnt_next = fill_cnt_reg;
    if (flush) begin
      state_next    = ST_FILL;
      fill_cnt_next = '0;
    end else if (in_valid && (state_reg == ST_FILL)) begin
      if (fill_cnt_reg == LOG2_WIN'(N - 1)) begin
        state_next    = ST_RUN;
        fill_cnt_next = '0;
      end else begin
        fill_cnt_next = fill_cnt_reg + LOG2_WIN'(1);
      end
    end
  end

  // Output logic: retire the oldest sample before adding the new one so the
  // unsigned sum never underflows (sum always includes the oldest entry).
  always_comb begin
    sum_next       = sum_reg;
    out_data_next  = out_data_reg;
    out_valid_next = 1'b0;
    filled_next    = (state_next == ST_RUN);
    if (flush) begin
      sum_next      = '0;
      out_data_next = '0;
    end else if (accept) begin
      sum_next      = (sum_reg - {{LOG2_WIN{1'b0}}, oldest}) + {{LOG2_WIN{1'b0}}, in_data};
      out_data_next = sum_next[SUM_W-1:LOG2_WIN];
`ifdef MAF_WARMUP_EN
      out_valid_next = (state_next == ST_RUN);
`else
      out_valid_next = 1'b1;
`endif
    end
  end

  // Output registers; the running sum doubles as out_sum.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_reg       <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      filled_reg    <= 1'b0;
    end else begin
      sum_reg       <= sum_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      filled_reg    <= filled_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_sum   = sum_reg;
  assign filled    = filled_reg;

endmodule

// File: tb/tb_moving_average_filter.sv
// Scoreboard bench for moving_average_filter (DATA_W=10, LOG2_WIN=3).
// The reference model keeps the last N accepted samples in a queue and sums
// them directly; expectations are queued at stimulus time and popped by an
// independent monitor whenever out_valid is seen.
module tb_moving_average_filter;

  localparam int DATA_W   = 10;
  localparam int LOG2_WIN = 3;
  localparam int N        = 1 << LOG2_WIN;
  localparam int SUM_W    = DATA_W + LOG2_WIN;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [SUM_W-1:0]  out_sum;
  logic              filled;

  moving_average_filter #(
    .DATA_W   (DATA_W),
    .LOG2_WIN (LOG2_WIN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sum   (out_sum),
    .filled    (filled)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sum;
    int data;
    bit filled;
  } exp_t;

  exp_t exp_q[$];
  int   win_q[$];
  int   accepted = 0;
  int   errors = 0;
  int   checks = 0;
  int   txn = 0;

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, required);
    end
  endtask

  // Reference model: window = last N accepted samples since reset/flush.
  task automatic model_clear();
    win_q.delete();
    accepted = 0;
  endtask

  task automatic model_accept(input int d);
    exp_t e;
    int   s;
    win_q.push_back(d);
    if (win_q.size() > N) void'(win_q.pop_front());
    accepted++;
    s = 0;
    foreach (win_q[i]) s += win_q[i];
    e.sum    = s;
    e.data   = s / N;
    e.filled = (accepted >= N);
`ifdef MAF_WARMUP_EN
    if (accepted >= N) exp_q.push_back(e);
`else
    exp_q.push_back(e);
`endif
  endtask

  // One clock of stimulus; inputs change 1 time unit after the rising edge.
  task automatic cycle(input bit v, input int d, input bit f, input bit r);
    @(posedge clk);
    #1;
    in_valid = v;
    in_data  = DATA_W'(d);
    flush    = f;
    reset    = r;
    if (r || f) model_clear();
    else if (v) model_accept(d);
  endtask

  task automatic check_zero_outputs(input string tag);
    @(negedge clk);
    check({tag, "_valid"},  int'(out_valid), 0);
    check({tag, "_data"},   int'(out_data), 0);
    check({tag, "_sum"},    int'(out_sum), 0);
    check({tag, "_filled"}, int'(filled), 0);
  endtask

  // Monitor: every out_valid pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        txn++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid: got sum=%0d with no output expected", out_sum);
        end else begin
          e = exp_q.pop_front();
          $display("txn %0d: sum=%0d data=%0d filled=%0d (exp %0d %0d %0d)",
                   txn, out_sum, out_data, filled, e.sum, e.data, e.filled);
          check("out_sum",  int'(out_sum),  e.sum);
          check("out_data", int'(out_data), e.data);
          check("filled",   int'(filled),   int'(e.filled));
        end
      end
    end
  end

  initial begin
    // Reset state.
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    check_zero_outputs("reset");

    // Constant 100 ramp up to steady state.
    for (int i = 0; i < 20; i++) cycle(1, 100, 0, 0);

    // Full-scale window then step to zero.
    for (int i = 0; i < 8; i++) cycle(1, 1023, 0, 0);
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 0);

    // Alternating valid with a rising ramp, crossing pointer wrap.
    for (int i = 0; i < 24; i++) cycle(i % 2 == 0, 8 * (i / 2 + 1), 0, 0);

    // Flush in RUN with a coincident sample that must be dropped.
    for (int i = 0; i < 10; i++) cycle(1, 50 + i, 0, 0);
    cycle(1, 999, 1, 0);
    cycle(0, 0, 0, 0);
    check_zero_outputs("flush");
    for (int i = 0; i < 10; i++) cycle(1, 200 + 3 * i, 0, 0);

    // Reset mid-stream at sample 5, then restart constant 100.
    for (int i = 0; i < 4; i++) cycle(1, 300, 0, 0);
    cycle(1, 300, 0, 1);
    cycle(0, 0, 0, 0);
    check_zero_outputs("midreset");
    for (int i = 0; i < 20; i++) cycle(1, 100, 0, 0);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      automatic int  p = int'($urandom_range(0, 99));
      automatic bit  v = (p < 75);
      automatic bit  f = (p >= 96);
      automatic bit  r = (p == 95);
      automatic int  d = (p < 10) ? 1023 : int'($urandom_range(0, 1023));
      cycle(v, d, f, r);
    end

    // Drain and confirm nothing expected is left outstanding.
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
    @(negedge clk);
    check("outstanding_expected", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
